// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and helpers for the pipeline hazard controller.
package pipe_hazard_ctrl_pkg;

  localparam int REG_AWIDTH = 5;

  typedef enum logic [1:0] {
    PHC_RUN      = 2'd0,
    PHC_MEM_WAIT = 2'd1,
    PHC_REDIRECT = 2'd2
  } phc_state_e;

  // True when an operand that the ID instruction actually reads names register rd.
  function automatic logic src_hit(input logic                  use_src,
                                   input logic [REG_AWIDTH-1:0] src,
                                   input logic [REG_AWIDTH-1:0] rd);
    return use_src && (src == rd);
  endfunction

endpackage

// File: rtl/pipe_perf_cnt.sv
// 32-bit enable counter with synchronous reset; wraps at 2^32.
module pipe_perf_cnt (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  output logic [31:0] cnt
);

  // Count every enabled cycle.
  always_ff @(posedge clk) begin
    if (rst) cnt <= '0;
    else if (en) cnt <= cnt + 32'd1;
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: stall/flush enables for PC, IF/ID and ID/EX.
// Optional performance counters (stall_cnt, flush_cnt) under PIPE_CTRL_PERF_EN.
//
//   state        | meaning
//   -------------+-----------------------------------------------------------
//   PHC_RUN      | normal flow; load-use and redirect detected here
//   PHC_MEM_WAIT | data memory/UART access pending, whole front end held
//   PHC_REDIRECT | flushing the wrong-path instructions after a redirect
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int REDIRECT_PENALTY = 2,
  parameter int MEM_TIMEOUT      = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_AWIDTH-1:0] id_rs1_addr,
  input  logic [REG_AWIDTH-1:0] id_rs2_addr,
  input  logic                  id_uses_rs1,
  input  logic                  id_uses_rs2,
  input  logic [REG_AWIDTH-1:0] ex_rd_addr,
  input  logic                  ex_is_load,
  input  logic                  ex_wb,
  input  logic                  ex_redirect,
  input  logic                  mem_req,
  input  logic                  mem_ready,
  output logic                  pc_stall,
  output logic                  if_id_stall,
  output logic                  if_id_flush,
  output logic                  id_ex_stall,
  output logic                  id_ex_flush,
  output logic                  timeout_err
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [31:0]           stall_cnt,
  output logic [31:0]           flush_cnt
`endif
);

  localparam logic [2:0]  PEN_LOAD  = 3'(REDIRECT_PENALTY - 1);
  localparam logic [15:0] WAIT_LOAD = 16'(MEM_TIMEOUT - 1);

  phc_state_e  state_q, state_d, ret_q, ret_d, eff_state;
  logic [2:0]  pen_q, pen_d;
  logic [15:0] wait_q, wait_d;
  logic        err_q, err_d;
  logic        load_use, in_wait, stalling, redirecting, load_stall;

  // Hazard classification shared by the next-state and output logic.
  always_comb begin
    load_use = ex_is_load && ex_wb && (ex_rd_addr != '0) &&
               (src_hit(id_uses_rs1, id_rs1_addr, ex_rd_addr) ||
                src_hit(id_uses_rs2, id_rs2_addr, ex_rd_addr));
    in_wait  = (state_q == PHC_MEM_WAIT);
    // In the mem_ready cycle the pre-wait state takes over immediately.
    eff_state   = in_wait ? ret_q : state_q;
    stalling    = in_wait ? !mem_ready : (mem_req && !mem_ready);
    redirecting = !stalling &&
                  ((eff_state == PHC_REDIRECT) || ((eff_state == PHC_RUN) && ex_redirect));
    load_stall  = !stalling && !redirecting && load_use;
  end

  // State, penalty/timeout down-counters and sticky error.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= PHC_RUN;
      ret_q   <= PHC_RUN;
      pen_q   <= '0;
      wait_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ret_q   <= ret_d;
      pen_q   <= pen_d;
      wait_q  <= wait_d;
      err_q   <= err_d;
    end
  end

  // Next-state logic; the penalty counter is untouched while waiting.
  always_comb begin
    state_d = state_q;
    ret_d   = ret_q;
    pen_d   = pen_q;
    wait_d  = wait_q;
    err_d   = err_q;
    if (stalling) begin
      state_d = PHC_MEM_WAIT;
      if (!in_wait) begin
        ret_d  = state_q;
        wait_d = WAIT_LOAD;
        if (WAIT_LOAD == '0) err_d = 1'b1;
      end else begin
        if (wait_q == 16'd1) err_d = 1'b1;
        if (wait_q != '0) wait_d = wait_q - 16'd1;
      end
    end else if (eff_state == PHC_REDIRECT) begin
      if (pen_q <= 3'd1) begin
        state_d = PHC_RUN;
        pen_d   = '0;
      end else begin
        state_d = PHC_REDIRECT;
        pen_d   = pen_q - 3'd1;
      end
    end else begin
      state_d = PHC_RUN;
      if (ex_redirect) begin
        pen_d   = PEN_LOAD;
        state_d = (PEN_LOAD != '0) ? PHC_REDIRECT : PHC_RUN;
      end
    end
  end

  // Combinational stall/flush enables; reset forces a pipeline clear.
  always_comb begin
    pc_stall    = 1'b0;
    if_id_stall = 1'b0;
    if_id_flush = 1'b0;
    id_ex_stall = 1'b0;
    id_ex_flush = 1'b0;
    timeout_err = err_q;
    if (rst) begin
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else begin
      pc_stall    = stalling || load_stall;
      if_id_stall = stalling || load_stall;
      id_ex_stall = stalling;
      if_id_flush = redirecting;
      id_ex_flush = redirecting || load_stall;
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  pipe_perf_cnt u_stall_cnt (.clk(clk), .rst(rst), .en(pc_stall),    .cnt(stall_cnt));
  pipe_perf_cnt u_flush_cnt (.clk(clk), .rst(rst), .en(id_ex_flush), .cnt(flush_cnt));
`endif

endmodule
